// File: rtl/xm_pkg.sv
// Shared definitions for the X-Makina instruction fetch path.
package xm_pkg;

  localparam int WORD = 16;
  localparam logic [WORD-1:0] RESET_VEC_DEF = 16'h0000;
  localparam logic [WORD-1:0] ALIGN_MASK = {{(WORD-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    F_IDLE    = 2'd0,
    F_REQ     = 2'd1,
    F_DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [WORD-1:0] inst;
    logic [WORD-1:0] pc;
  } fetch_entry_t;

  // Instructions are halfword aligned; bit 0 of any target is dropped.
  function automatic logic [WORD-1:0] align_half(input logic [WORD-1:0] adr);
    return adr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/xm_fetch_buf.sv
// Two-entry {inst, pc} FIFO; slot 0 is always the head so every output is a flop.
module xm_fetch_buf
  import xm_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t head,
  output logic         valid,
  output logic [1:0]   count
);

  fetch_entry_t slot_reg [2];
  logic [1:0]   count_reg;
  logic [1:0]   count_next;
  logic         valid_reg;
  logic         pop_eff;

  // A pop against an empty buffer is ignored.
  assign pop_eff = pop && (count_reg != 2'd0);

  always_comb begin
    count_next = count_reg;
    if (flush) begin
      count_next = 2'd0;
    end else if (push && !pop_eff) begin
      count_next = count_reg + 2'd1;
    end else if (!push && pop_eff) begin
      count_next = count_reg - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_reg[0] <= '0;
      slot_reg[1] <= '0;
      count_reg   <= 2'd0;
      valid_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      valid_reg <= (count_next != 2'd0);
      if (!flush) begin
        assert (!(push && !pop_eff && count_reg == 2'd2));
        case ({push, pop_eff})
          2'b10: begin
            if (count_reg == 2'd0) slot_reg[0] <= wr_entry;
            else                   slot_reg[1] <= wr_entry;
          end
          2'b01: begin
            slot_reg[0] <= slot_reg[1];
          end
          2'b11: begin
            // Head leaves while a new word arrives: the new word lands behind
            // whatever survives the pop.
            if (count_reg == 2'd1) begin
              slot_reg[0] <= wr_entry;
            end else begin
              slot_reg[0] <= slot_reg[1];
              slot_reg[1] <= wr_entry;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign head  = slot_reg[0];
  assign valid = valid_reg;
  assign count = count_reg;

endmodule

// File: rtl/xm_inst_fetch.sv
// Instruction fetch unit: fetch FSM, fetch PC and memory request registers around a 2-deep buffer.
module xm_inst_fetch
  import xm_pkg::*;
#(
  parameter logic [WORD-1:0] RESET_VEC = RESET_VEC_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            memReq_o,
  output logic [WORD-1:0] memAdr_o,
  input  logic            memAck_i,
  input  logic [WORD-1:0] memData_i,
  input  logic            redirect_i,
  input  logic [WORD-1:0] redirectAdr_i,
  output logic            instValid_o,
  output logic [WORD-1:0] inst_o,
  output logic [WORD-1:0] instPc_o,
  input  logic            instReady_i
);

  fetch_state_t    state_reg;
  logic [WORD-1:0] fetch_pc_reg;
  logic [WORD-1:0] pc_next_seq;
  logic [WORD-1:0] target;
  logic            req_reg;
  logic [WORD-1:0] adr_reg;

  logic            buf_push;
  logic            buf_pop;
  logic            pop_eff;
  logic            buf_valid;
  logic [1:0]      buf_count;
  logic [1:0]      count_after;
  fetch_entry_t    buf_head;
  fetch_entry_t    wr_entry;

  assign pc_next_seq = fetch_pc_reg + WORD'(2);
  assign target      = align_half(redirectAdr_i);

  // Only a live read may fill the buffer; a redirect on the ack edge kills it.
  assign buf_push = (state_reg == F_REQ) && memAck_i && !redirect_i;
  assign buf_pop  = instReady_i && buf_valid;
  assign pop_eff  = buf_pop && (buf_count != 2'd0);
  assign wr_entry = '{inst: memData_i, pc: fetch_pc_reg};

  always_comb begin
    count_after = buf_count;
    if (buf_push && !pop_eff) begin
      count_after = buf_count + 2'd1;
    end else if (!buf_push && pop_eff) begin
      count_after = buf_count - 2'd1;
    end
  end

  xm_fetch_buf u_buf (
    .clk      (clk_i),
    .rst      (rst_i),
    .push     (buf_push),
    .pop      (buf_pop),
    .flush    (redirect_i),
    .wr_entry (wr_entry),
    .head     (buf_head),
    .valid    (buf_valid),
    .count    (buf_count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= F_IDLE;
      fetch_pc_reg <= RESET_VEC;
      req_reg      <= 1'b0;
      adr_reg      <= RESET_VEC;
    end else if (redirect_i) begin
      fetch_pc_reg <= target;
      case (state_reg)
        F_IDLE: begin
          state_reg <= F_REQ;
          req_reg   <= 1'b1;
          adr_reg   <= target;
        end
        F_REQ: begin
          if (memAck_i) begin
            state_reg <= F_REQ;
            adr_reg   <= target;
          end else begin
            // The old read must still complete at its original address.
            state_reg <= F_DISCARD;
          end
        end
        F_DISCARD: ;
        default: begin
          state_reg <= F_IDLE;
          req_reg   <= 1'b0;
        end
      endcase
    end else begin
      case (state_reg)
        F_IDLE: begin
          if (count_after < 2'd2) begin
            state_reg <= F_REQ;
            req_reg   <= 1'b1;
            adr_reg   <= fetch_pc_reg;
          end
        end
        F_REQ: begin
          if (memAck_i) begin
            fetch_pc_reg <= pc_next_seq;
            adr_reg      <= pc_next_seq;
            if (count_after < 2'd2) begin
              state_reg <= F_REQ;
              req_reg   <= 1'b1;
            end else begin
              state_reg <= F_IDLE;
              req_reg   <= 1'b0;
            end
          end
        end
        F_DISCARD: begin
          if (memAck_i) begin
            state_reg <= F_REQ;
            adr_reg   <= fetch_pc_reg;
          end
        end
        default: begin
          state_reg <= F_IDLE;
          req_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign memReq_o    = req_reg;
  assign memAdr_o    = adr_reg;
  assign instValid_o = buf_valid;
  assign inst_o      = buf_head.inst;
  assign instPc_o    = buf_head.pc;

endmodule

// File: tb/tb_xm_inst_fetch.sv
// Directed bench for xm_inst_fetch; memory returns a fixed scramble of the address.
module tb_xm_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [15:0] mem_adr;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic        redirect;
  logic [15:0] redirect_adr;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        inst_ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  xm_inst_fetch dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .memReq_o      (mem_req),
    .memAdr_o      (mem_adr),
    .memAck_i      (mem_ack),
    .memData_i     (mem_data),
    .redirect_i    (redirect),
    .redirectAdr_i (redirect_adr),
    .instValid_o   (inst_valid),
    .inst_o        (inst),
    .instPc_o      (inst_pc),
    .instReady_i   (inst_ready)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3C3;
  endfunction

  assign mem_data = mem_word(mem_adr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_req(input string tag, input logic req, input logic [15:0] adr);
    check({tag, "_req"}, 32'(mem_req), 32'(req));
    check({tag, "_adr"}, 32'(mem_adr), 32'(adr));
  endtask

  task automatic check_head(input string tag, input logic v, input logic [15:0] pc);
    check({tag, "_valid"}, 32'(inst_valid), 32'(v));
    if (v) begin
      check({tag, "_inst"}, 32'(inst), 32'(mem_word(pc)));
      check({tag, "_pc"}, 32'(inst_pc), 32'(pc));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; mem_ack = 1'b0; redirect = 1'b0; redirect_adr = 16'h0000; inst_ready = 1'b1;
    tick; tick;
    check_req("rst", 1'b0, 16'h0000);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", 32'(inst), 32'd0);
    check("rst_pc", 32'(inst_pc), 32'd0);

    // Streaming with zero-wait memory and an always-ready consumer.
    rst = 1'b0; tick;
    check_req("t1_start", 1'b1, 16'h0000);
    mem_ack = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick;
      check_req("t1_seq", 1'b1, 16'(2 * k));
      check_head("t1_seq", 1'b1, 16'(2 * k - 2));
    end

    // Stalled consumer: two acks fill the buffer, request drops, one pop restarts it.
    rst = 1'b1; mem_ack = 1'b0; tick;
    rst = 1'b0; tick;
    check_req("t2_start", 1'b1, 16'h0000);
    inst_ready = 1'b0; mem_ack = 1'b1;
    tick;
    check_req("t2_fill1", 1'b1, 16'h0002);
    check_head("t2_fill1", 1'b1, 16'h0000);
    tick;
    check("t2_full_req", 32'(mem_req), 32'd0);
    check_head("t2_full", 1'b1, 16'h0000);
    tick;
    check("t2_idle_req", 32'(mem_req), 32'd0);
    check_head("t2_idle", 1'b1, 16'h0000);
    inst_ready = 1'b1; tick;
    inst_ready = 1'b0; mem_ack = 1'b0;
    check_req("t2_pop", 1'b1, 16'h0004);
    check_head("t2_pop", 1'b1, 16'h0002);
    tick;
    check_req("t2_hold", 1'b1, 16'h0004);

    // Redirect during a slow read: old address held, its data discarded.
    rst = 1'b1; tick;
    rst = 1'b0; inst_ready = 1'b1; tick;
    check_req("t3_start", 1'b1, 16'h0000);
    redirect = 1'b1; redirect_adr = 16'h0101; tick;
    redirect = 1'b0;
    check_req("t3_disc0", 1'b1, 16'h0000);
    check_head("t3_disc0", 1'b0, 16'h0000);
    tick;
    check_req("t3_disc1", 1'b1, 16'h0000);
    mem_ack = 1'b1; tick;
    mem_ack = 1'b0;
    check_req("t3_new", 1'b1, 16'h0100);
    check_head("t3_new", 1'b0, 16'h0000);
    tick;
    check_req("t3_wait", 1'b1, 16'h0100);
    check_head("t3_wait", 1'b0, 16'h0000);
    mem_ack = 1'b1; tick;
    mem_ack = 1'b0;
    check_req("t3_ack", 1'b1, 16'h0102);
    check_head("t3_ack", 1'b1, 16'h0100);

    // Redirect on the ack edge: data dropped, buffer flushed, target issued next.
    mem_ack = 1'b1; redirect = 1'b1; redirect_adr = 16'h2345; tick;
    redirect = 1'b0; mem_ack = 1'b0;
    check_req("t4_coinc", 1'b1, 16'h2344);
    check_head("t4_coinc", 1'b0, 16'h0000);

    // Fetch PC wrap from FFFE to 0000.
    mem_ack = 1'b1; redirect = 1'b1; redirect_adr = 16'hFFFF; tick;
    redirect = 1'b0;
    check_req("t5_target", 1'b1, 16'hFFFE);
    check_head("t5_target", 1'b0, 16'h0000);
    tick;
    check_req("t5_wrap", 1'b1, 16'h0000);
    check_head("t5_wrap", 1'b1, 16'hFFFE);
    tick;
    check_req("t5_after", 1'b1, 16'h0002);
    check_head("t5_after", 1'b1, 16'h0000);

    // Reset with a read outstanding and buffered data.
    mem_ack = 1'b0; inst_ready = 1'b0; tick;
    check_req("t6_pend", 1'b1, 16'h0002);
    check_head("t6_pend", 1'b1, 16'h0000);
    rst = 1'b1; tick;
    rst = 1'b0;
    check_req("t6_rst", 1'b0, 16'h0000);
    check("t6_rst_valid", 32'(inst_valid), 32'd0);
    check("t6_rst_inst", 32'(inst), 32'd0);
    check("t6_rst_pc", 32'(inst_pc), 32'd0);
    tick;
    check_req("t6_restart", 1'b1, 16'h0000);

    // Redirect from the idle (full) state.
    mem_ack = 1'b1; tick;
    check_req("t7_fill1", 1'b1, 16'h0002);
    check_head("t7_fill1", 1'b1, 16'h0000);
    tick;
    mem_ack = 1'b0;
    check("t7_full_req", 32'(mem_req), 32'd0);
    redirect = 1'b1; redirect_adr = 16'h0040; tick;
    redirect = 1'b0;
    check_req("t7_redir", 1'b1, 16'h0040);
    check_head("t7_redir", 1'b0, 16'h0000);
    mem_ack = 1'b1; tick;
    mem_ack = 1'b0;
    check_req("t7_next", 1'b1, 16'h0042);
    check_head("t7_next", 1'b1, 16'h0040);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
